// File: rtl/misr_cmp_param.sv
// misr_cmp_param: parametrised Galois MISR scan-output compactor.
// Folds N_IN channels onto SIG_W stages, compacts qualified samples over a
// programmable window, then registers done/pass against a golden signature.
module misr_cmp_param #(
   parameter int unsigned       SIG_W   = 13,
   parameter int unsigned       N_IN    = 11,
   parameter logic [SIG_W-1:0]  POLY    = 13'h001B,
   parameter logic [SIG_W-1:0]  SEED    = '0,
   parameter int unsigned       CNT_W   = 20,
   parameter int unsigned       SE_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [N_IN-1:0]  sc_out,
   input  logic             sample_en,
   input  logic             test_se,
   input  logic [CNT_W-1:0] scan_num,
   input  logic [SIG_W-1:0] golden,
   output logic [SIG_W-1:0] sig,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Channels are zero-padded to whole SIG_W-wide slices and the slices XORed.
   localparam int unsigned NCH   = (N_IN + SIG_W - 1) / SIG_W;
   localparam int unsigned PAD_W = NCH * SIG_W;

   logic [1:0]       state_q, state_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic             q;
   logic [PAD_W-1:0] sc_pad;
   logic [SIG_W-1:0] fold_acc [NCH];
   logic [SIG_W-1:0] fold;
   logic [SIG_W-1:0] sig_nxt;

   assign sc_pad = PAD_W'(sc_out);

   for (genvar c = 0; c < NCH; c++) begin : g_fold
      if (c == 0) begin : g_first
         assign fold_acc[c] = sc_pad[SIG_W-1:0];
      end else begin : g_rest
         assign fold_acc[c] = fold_acc[c-1] ^ sc_pad[c*SIG_W +: SIG_W];
      end
   end
   assign fold = fold_acc[NCH-1];

   // Qualify samples by scan-enable mode; an illegal mode behaves as ungated.
   always_comb begin
      case (SE_MODE)
         1:       q = sample_en & test_se;
         2:       q = sample_en & ~test_se;
         default: q = sample_en;
      endcase
   end

   // Session control and compaction; priority abort > start > sample.
   always_comb begin
      state_d      = state_q;
      sig_d        = sig_q;
      sample_cnt_d = sample_cnt_q;
      target_d     = target_q;
      done_d       = done_q;
      pass_d       = pass_q;
      sig_nxt      = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (POLY & {SIG_W{sig_q[SIG_W-1]}})
                   ^ fold;

      if (abort) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else if (start) begin
         sig_d        = SEED;
         sample_cnt_d = '0;
         target_d     = scan_num;
         if (scan_num == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (SEED == golden);
         end else begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      end else if (state_q == ST_RUN && q) begin
         sig_d        = sig_nxt;
         sample_cnt_d = sample_cnt_q + CNT_W'(1);
         // Terminal test uses target-1 so target = 2^CNT_W-1 never wraps the counter.
         if (sample_cnt_q == target_q - CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (sig_nxt == golden);
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sig_q        <= SEED;
         sample_cnt_q <= '0;
         target_q     <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sig_q        <= sig_d;
         sample_cnt_q <= sample_cnt_d;
         target_q     <= target_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign sig        = sig_q;
   assign sample_cnt = sample_cnt_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = done_q;
   assign pass       = pass_q;

endmodule

// File: tb/tb_misr_cmp_param.sv
// Bench for misr_cmp_param: two instances (ungated 6-channel folding, and
// scan-enable-gated 4-channel with a nonzero seed and 3-bit counter) checked
// every cycle against a polynomial-arithmetic model plus literal vectors.
module tb_misr_cmp_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       sample_en = 1'b0;
   logic       test_se = 1'b0;
   logic [5:0] sc_out = '0;
   logic [7:0] scan_num = '0;
   logic [3:0] golden = '0;

   logic [3:0] sig_a, sig_b;
   logic [7:0] cnt_a;
   logic [2:0] cnt_b;
   logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;

   int n_chk = 0;
   int n_fail = 0;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   misr_cmp_param #(
      .SIG_W(4), .N_IN(6), .POLY(4'b0011), .SEED(4'b0000), .CNT_W(8), .SE_MODE(0)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .sc_out(sc_out), .sample_en(sample_en), .test_se(test_se),
      .scan_num(scan_num), .golden(golden),
      .sig(sig_a), .sample_cnt(cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a)
   );

   misr_cmp_param #(
      .SIG_W(4), .N_IN(4), .POLY(4'b0011), .SEED(4'b1001), .CNT_W(3), .SE_MODE(1)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .sc_out(sc_out[3:0]), .sample_en(sample_en), .test_se(test_se),
      .scan_num(scan_num[2:0]), .golden(golden),
      .sig(sig_b), .sample_cnt(cnt_b), .busy(busy_b), .done(done_b), .pass(pass_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_st  [2];
   logic [3:0]  m_sig [2];
   int unsigned m_cnt [2];
   int unsigned m_tgt [2];
   logic        m_pass[2];

   function automatic logic [3:0] seed_of(input int k);
      return (k == 0) ? 4'b0000 : 4'b1001;
   endfunction

   // Channel i lands on stage i mod 4.
   function automatic logic [3:0] fold_of(input logic [5:0] d, input int n);
      int v;
      v = 0;
      for (int i = 0; i < n; i++)
         if (d[i]) v = v ^ (1 << (i % 4));
      return 4'(v);
   endfunction

   // s*x + f modulo x^4 + x + 1
   function automatic logic [3:0] galois(input logic [3:0] s, input logic [3:0] f);
      int v;
      v = int'(s) * 2;
      if (v >= 16) v = v ^ 'h13;
      return 4'(v) ^ f;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_sig[k] = seed_of(k);
            m_cnt[k] = 0; m_tgt[k] = 0; m_pass[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            int unsigned n;
            logic        qk;
            logic [3:0]  f;
            n  = (k == 0) ? int'(scan_num) : int'(scan_num) % 8;
            qk = sample_en && (k == 0 || test_se);
            f  = fold_of(sc_out, (k == 0) ? 6 : 4);
            if (abort) begin
               m_st[k] = M_IDLE; m_pass[k] = 1'b0;
            end else if (start) begin
               m_sig[k] = seed_of(k); m_cnt[k] = 0; m_tgt[k] = n;
               if (n == 0) begin
                  m_st[k] = M_DONE; m_pass[k] = (seed_of(k) == golden);
               end else begin
                  m_st[k] = M_RUN;
               end
            end else if (m_st[k] == M_RUN && qk) begin
               m_sig[k] = galois(m_sig[k], f);
               m_cnt[k] = m_cnt[k] + 1;
               if (m_cnt[k] == m_tgt[k]) begin
                  m_st[k] = M_DONE; m_pass[k] = (m_sig[k] == golden);
               end
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("A.sig",  sig_a,  m_sig[0]);
      chk("A.cnt",  cnt_a,  m_cnt[0]);
      chk("A.busy", busy_a, m_st[0] == M_RUN);
      chk("A.done", done_a, m_st[0] == M_DONE);
      if (m_st[0] == M_DONE) chk("A.pass", pass_a, m_pass[0]);
      chk("B.sig",  sig_b,  m_sig[1]);
      chk("B.cnt",  cnt_b,  m_cnt[1]);
      chk("B.busy", busy_b, m_st[1] == M_RUN);
      chk("B.done", done_b, m_st[1] == M_DONE);
      if (m_st[1] == M_DONE) chk("B.pass", pass_b, m_pass[1]);
   end

   // One clock of stimulus, applied at negedge, returning 1 after the posedge.
   task automatic drive(input logic st, input logic ab, input logic en, input logic tse,
                        input logic [5:0] d, input logic [7:0] n, input logic [3:0] g);
      @(negedge clk);
      start = st; abort = ab; sample_en = en; test_se = tse;
      sc_out = d; scan_num = n; golden = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst A.sig", sig_a, 4'h0);
      chk("rst A.cnt", cnt_a, 0);
      chk("rst A.busy", busy_a, 0);
      chk("rst A.done", done_a, 0);
      chk("rst A.pass", pass_a, 0);
      chk("rst B.sig", sig_b, 4'b1001);
      @(negedge clk);
      rst_n = 1'b1;

      // arithmetic: 0001, 1000, 0000 -> 0001, 1010, 0111
      drive(1, 0, 0, 0, 6'b000000, 3, 4'b0111);
      chk("ar busy", busy_a, 1);
      drive(0, 0, 1, 0, 6'b000001, 3, 4'b0111);
      chk("ar sig1", sig_a, 4'b0001);
      drive(0, 0, 1, 0, 6'b001000, 3, 4'b0111);
      chk("ar sig2", sig_a, 4'b1010);
      chk("ar done early", done_a, 0);
      drive(0, 0, 1, 0, 6'b000000, 3, 4'b0111);
      chk("ar sig3", sig_a, 4'b0111);
      chk("ar done", done_a, 1);
      chk("ar pass", pass_a, 1);
      chk("ar cnt", cnt_a, 3);
      drive(0, 0, 1, 0, 6'b111111, 3, 4'b0111);
      chk("ar hold sig", sig_a, 4'b0111);
      // same stream, wrong golden
      drive(1, 0, 0, 0, 6'b000000, 3, 4'b0110);
      drive(0, 0, 1, 0, 6'b000001, 3, 4'b0110);
      drive(0, 0, 1, 0, 6'b001000, 3, 4'b0110);
      drive(0, 0, 1, 0, 6'b000000, 3, 4'b0110);
      chk("ar2 done", done_a, 1);
      chk("ar2 pass", pass_a, 0);

      // folding
      drive(1, 0, 0, 0, 6'b000000, 1, 4'b0000);
      drive(0, 0, 1, 0, 6'b110000, 1, 4'b0000);
      chk("fold 110000", sig_a, 4'b0011);
      chk("fold done", done_a, 1);
      drive(1, 0, 0, 0, 6'b000000, 1, 4'b0000);
      drive(0, 0, 1, 0, 6'b010001, 1, 4'b0000);
      chk("fold 010001", sig_a, 4'b0000);
      drive(1, 0, 0, 0, 6'b000000, 1, 4'b0000);
      drive(0, 0, 1, 0, 6'b010010, 1, 4'b0000);
      chk("fold 010010", sig_a, 4'b0011);

      // scan-enable gating on instance B
      drive(1, 0, 0, 0, 6'b000000, 2, 4'b0000);
      drive(0, 0, 1, 1, 6'b000001, 2, 4'b0000);
      chk("se cnt1", cnt_b, 1);
      drive(0, 0, 1, 0, 6'b000100, 2, 4'b0000);
      chk("se cnt2", cnt_b, 1);
      chk("se not done", done_b, 0);
      drive(0, 0, 1, 1, 6'b000010, 2, 4'b0000);
      chk("se cnt3", cnt_b, 2);
      chk("se done", done_b, 1);
      chk("se sig", sig_b, 4'b0010);
      drive(0, 0, 1, 0, 6'b000000, 2, 4'b0000);
      chk("se hold", cnt_b, 2);

      // zero length
      drive(1, 0, 0, 0, 6'b000000, 0, 4'b1001);
      chk("zl A.done", done_a, 1);
      chk("zl A.sig", sig_a, 4'b0000);
      chk("zl A.cnt", cnt_a, 0);
      chk("zl A.pass", pass_a, 0);
      chk("zl B.sig", sig_b, 4'b1001);
      chk("zl B.pass", pass_b, 1);
      // abort in DONE clears done/pass
      drive(0, 1, 0, 0, 6'b000000, 0, 4'b1001);
      chk("ab done", done_b, 0);
      chk("ab pass", pass_b, 0);

      // abort mid-run
      drive(1, 0, 0, 0, 6'b000000, 5, 4'b0000);
      drive(0, 0, 1, 0, 6'b000001, 5, 4'b0000);
      drive(0, 0, 1, 0, 6'b000011, 5, 4'b0000);
      drive(0, 1, 0, 0, 6'b000000, 5, 4'b0000);
      chk("abrun done", done_a, 0);
      chk("abrun busy", busy_a, 0);
      chk("abrun cnt", cnt_a, 2);
      // start+abort together stays idle
      drive(1, 1, 0, 0, 6'b000000, 5, 4'b0000);
      chk("sa busy", busy_a, 0);
      chk("sa cnt", cnt_a, 2);

      // restart in RUN
      drive(1, 0, 0, 0, 6'b000000, 5, 4'b0000);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 6'(i + 3), 5, 4'b0000);
      drive(1, 0, 1, 0, 6'b111111, 5, 4'b0000);
      chk("rs cnt", cnt_a, 0);
      chk("rs sig", sig_a, 4'b0000);
      chk("rs busy", busy_a, 1);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 6'(i * 5 + 1), 5, 4'b0000);
      chk("rs cnt4", cnt_a, 4);
      chk("rs not done", done_a, 0);
      drive(0, 0, 1, 0, 6'b101010, 5, 4'b0000);
      chk("rs done", done_a, 1);
      chk("rs cnt5", cnt_a, 5);

      // full-scale targets: A 255, B 7 (2^3-1)
      drive(1, 0, 0, 0, 6'b000000, 8'hFF, 4'b0000);
      for (int i = 0; i < 255; i++) begin
         drive(0, 0, 1, 1, 6'(i * 7 + 3), 8'hFF, 4'b0000);
         if (i == 6) begin
            chk("max B.done", done_b, 1);
            chk("max B.cnt", cnt_b, 7);
         end
         if (i == 253) begin
            chk("max A.cnt254", cnt_a, 254);
            chk("max A.notdone", done_a, 0);
         end
      end
      chk("max A.done", done_a, 1);
      chk("max A.cnt", cnt_a, 255);

      // asynchronous reset mid-run
      drive(1, 0, 0, 0, 6'b000000, 5, 4'b0000);
      drive(0, 0, 1, 0, 6'b000101, 5, 4'b0000);
      chk("ar pre sig", sig_a, 4'b0101);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst A.sig", sig_a, 4'b0000);
      chk("arst A.cnt", cnt_a, 0);
      chk("arst A.busy", busy_a, 0);
      chk("arst B.sig", sig_b, 4'b1001);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 6'b000000, 1, 4'b0110);
      drive(0, 0, 1, 0, 6'b000110, 1, 4'b0110);
      chk("post sig", sig_a, 4'b0110);
      chk("post done", done_a, 1);
      chk("post pass", pass_a, 1);

      drive(0, 0, 0, 0, 6'b000000, 0, 4'b0000);
      drive(0, 0, 0, 0, 6'b000000, 0, 4'b0000);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
